o_ddr_tx: RTL and testbench
===========================

// Module: o_ddr_tx
// PURPOSE
//  Transmit-side DDR serializer; the output counterpart of the DDR input capture primitive.
//  Takes parallel words over a valid/ready handshake and drives them out 2 bits per clock on a single pin.
//  The high phase of C carries the even bit and the low phase carries the odd bit.
//  Sits between fabric logic and the output pad.
// PARAMETERS
//  WIDTH     8  word width in bits; must be even and >=2; WIDTH/2 clock cycles per word
//  LSB_FIRST 1  1: bit0 is sent first; 0: bit WIDTH-1 is sent first (the bit order is mirrored)
// PORTS
//  C           in   1      clock; the only clock
//  R           in   1      reset, synchronous, active-high
//  E           in   1      enable; 0 freezes all state
//  DATA_IN     in   WIDTH  parallel word to send
//  DATA_VALID  in   1      DATA_IN is valid
//  DATA_READY  out  1      block can accept a word this cycle
//  Q           out  1      DDR serial output: C=1 -> P[0], C=0 -> P[1]
//  OE          out  1      high while Q carries word data
//  FRAME       out  1      high during the cycle in which Q carries a word's first pair
// BEHAVIOUR
//  - Reset: a posedge C with R=1 clears everything; the holding buffer and any in-flight word are discarded.
//    The outputs become P=idle value, OE=0, FRAME=0, state IDLE. DATA_READY is 0 while R=1.
//  - Storage:
//    - Holding buffer HB (1 word) with flag HBF.
//    - Shift register SR, pair counter CNT of $clog2(WIDTH/2) bits, pair register P[1:0].
//  - Accept: at a posedge with E=1, DATA_VALID=1 and DATA_READY=1, DATA_IN is written to HB and HBF is set.
//  - Readiness: LOADNOW = HBF & (state==IDLE | CNT==0). DATA_READY = E & ~R & (~HBF | LOADNOW).
//    This is combinational from registers only, with no path from DATA_VALID.
//  - FSM IDLE:
//    - If HBF=1: load. SR<=HB, P<=first pair, CNT<=WIDTH/2-1, OE<=1, FRAME<=1, state<=SHIFT.
//    - Otherwise P<=idle value and OE<=0.
//  - FSM SHIFT:
//    - CNT!=0: P<=next pair from SR, shift SR by 2, CNT<=CNT-1, FRAME<=0.
//    - CNT==0 and HBF=1: load the next word seamlessly, with no gap cycle.
//    - CNT==0 and HBF=0: state<=IDLE, P<=idle value, OE<=0, FRAME<=0.
//  - Pair order:
//    - LSB_FIRST=1: pair k = {bit 2k+1, bit 2k}, with P[0]=bit 2k.
//    - LSB_FIRST=0: pair k has P[0]=bit W-1-2k and P[1]=bit W-2-2k.
//  - Latency: a word accepted at posedge n is loaded at posedge n+1. Its first bit is on Q in the high phase after n+1.
//    Its last pair occupies cycle n+WIDTH/2.
//  - Simultaneous accept and load: HB is read and rewritten at the same edge; HBF stays 1.
//    Sustained throughput is one word per WIDTH/2 cycles, including WIDTH=2.
//  - E=0: no accept, no load, no shift. P, OE and FRAME hold, so Q repeats the held pair each cycle.
//  - R takes priority over E. R asserted mid-word truncates the word at that edge.
//  - Q is a combinational mux of P on C, as a behavioural model. P changes only at posedge.
// CONFIGURATION
//  O_DDR_TX_TRAIN_PATTERN_EN
//    - Defined: the idle value of P is 2'b01, so Q outputs a forwarded-clock pattern (1 on high phase, 0 on low phase) whenever OE=0.
//    - Undefined: the idle value is 2'b00 and Q stays low while idle. Reset also uses this idle value.
// TESTING (WIDTH=8, LSB_FIRST=1 unless noted)
//  1. Reset: R=1 for 2 cycles with DATA_VALID=1 -> DATA_READY=0, Q=0 on both phases, OE=0, FRAME=0.
//  2. Single word 8'hB4 -> (high,low) pairs (0,0),(1,0),(1,1),(0,1) over 4 cycles after load.
//     OE=1 for those 4 cycles; FRAME=1 only in the first; then OE=0 and Q=0.
//  3. Back-to-back 8'hFF then 8'h00, DATA_VALID held high -> 8 contiguous cycles: Q=1,1 x4 then 0,0 x4.
//     OE stays 1 throughout; FRAME pulses at cycles 1 and 5.
//  4. E=0 for 3 cycles during the 2nd pair of 8'hB4 -> Q holds (1,0) for 3 extra cycles, then resumes (1,1),(0,1).
//     DATA_READY=0 while E=0.
//  5. R=1 during the 3rd pair with HB full -> at that edge OE=0 and Q idles. After release, no stale data is sent.
//  6. LSB_FIRST=0, word 8'hB4 -> pairs (1,0),(1,1),(0,1),(0,0).
//     With O_DDR_TX_TRAIN_PATTERN_EN defined, idle Q toggles 1/0 per phase.

Source files
------------

// File: rtl/o_ddr_tx.sv
// Transmit DDR serializer: valid/ready word intake, two bits per clock on one pin.
// Optional macro O_DDR_TX_TRAIN_PATTERN_EN makes the idle output a forwarded-clock pattern.
module o_ddr_tx #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic             C,
    input  logic             R,
    input  logic             E,
    input  logic [WIDTH-1:0] DATA_IN,
    input  logic             DATA_VALID,
    output logic             DATA_READY,
    output logic             Q,
    output logic             OE,
    output logic             FRAME
);

    localparam int unsigned NPAIR = WIDTH / 2;
    localparam int unsigned CW    = (NPAIR > 1) ? $clog2(NPAIR) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NPAIR - 1);

`ifdef O_DDR_TX_TRAIN_PATTERN_EN
    localparam logic [1:0] IDLE_P = 2'b01;
`else
    localparam logic [1:0] IDLE_P = 2'b00;
`endif

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] hb;
    logic             hbf;
    logic [WIDTH-1:0] sr;
    logic [CW-1:0]    cnt;
    logic [1:0]       p;
    logic             load_now;
    logic             accept;

    // Pair at the head of a word in transmit order; P[0] is the high-phase bit.
    function automatic logic [1:0] head_pair(input logic [WIDTH-1:0] w);
        if (LSB_FIRST) return {w[1], w[0]};
        else           return {w[WIDTH-2], w[WIDTH-1]};
    endfunction

    function automatic logic [WIDTH-1:0] drop_pair(input logic [WIDTH-1:0] w);
        if (LSB_FIRST) return w >> 2;
        else           return w << 2;
    endfunction

    assign load_now   = hbf & ((state == IDLE) | (cnt == '0));
    assign DATA_READY = E & ~R & (~hbf | load_now);
    assign accept     = DATA_VALID & DATA_READY;
    assign Q          = C ? p[0] : p[1];

    // SR holds only the pairs not yet moved into P, so a load pre-drops the head pair.
    always_ff @(posedge C) begin
        if (R) begin
            state <= IDLE;
            hb    <= '0;
            hbf   <= 1'b0;
            sr    <= '0;
            cnt   <= '0;
            p     <= IDLE_P;
            OE    <= 1'b0;
            FRAME <= 1'b0;
        end else if (E) begin
            if (accept) begin
                hb  <= DATA_IN;
                hbf <= 1'b1;
            end else if (load_now) begin
                hbf <= 1'b0;
            end

            if (load_now) begin
                sr    <= drop_pair(hb);
                p     <= head_pair(hb);
                cnt   <= CNT_LAST;
                OE    <= 1'b1;
                FRAME <= 1'b1;
                state <= SHIFT;
            end else if ((state == SHIFT) && (cnt != '0)) begin
                p     <= head_pair(sr);
                sr    <= drop_pair(sr);
                cnt   <= cnt - CW'(1);
                FRAME <= 1'b0;
            end else begin
                state <= IDLE;
                p     <= IDLE_P;
                OE    <= 1'b0;
                FRAME <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_o_ddr_tx.sv
// Bench for o_ddr_tx: LSB-first and MSB-first instances share stimulus; accepted words go to a scoreboard.
module tb_o_ddr_tx;

`ifdef O_DDR_TX_TRAIN_PATTERN_EN
    localparam logic IH = 1'b1;
    localparam logic IL = 1'b0;
`else
    localparam logic IH = 1'b0;
    localparam logic IL = 1'b0;
`endif
    // Observation vector: {lsb hi, lsb lo, lsb OE, lsb FRAME, msb hi, msb lo, msb OE, msb FRAME}
    localparam logic [7:0] IDLE_OBS = {IH, IL, 2'b00, IH, IL, 2'b00};

    logic       C = 1'b0;
    logic       R = 1'b1;
    logic       E = 1'b1;
    logic       DATA_VALID = 1'b0;
    logic [7:0] DATA_IN = 8'h00;
    logic       rdy_l, q_l, oe_l, fr_l;
    logic       rdy_m, q_m, oe_m, fr_m;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] sb[$];

    always #5 C = ~C;

    o_ddr_tx #(.WIDTH(8), .LSB_FIRST(1'b1)) u_lsb (
        .C(C), .R(R), .E(E), .DATA_IN(DATA_IN), .DATA_VALID(DATA_VALID),
        .DATA_READY(rdy_l), .Q(q_l), .OE(oe_l), .FRAME(fr_l)
    );

    o_ddr_tx #(.WIDTH(8), .LSB_FIRST(1'b0)) u_msb (
        .C(C), .R(R), .E(E), .DATA_IN(DATA_IN), .DATA_VALID(DATA_VALID),
        .DATA_READY(rdy_m), .Q(q_m), .OE(oe_m), .FRAME(fr_m)
    );

    // One clock: high phase sampled after posedge, low phase after negedge; inputs change afterwards.
    task automatic step(output logic [7:0] obs);
        @(posedge C);
        #2;
        obs[7] = q_l; obs[5] = oe_l; obs[4] = fr_l;
        obs[3] = q_m; obs[1] = oe_m; obs[0] = fr_m;
        @(negedge C);
        #2;
        obs[6] = q_l; obs[2] = q_m;
    endtask

    function automatic logic [7:0] exp_data(input logic [7:0] w, input int k, input logic fr);
        logic [7:0] l;
        logic [7:0] m;
        l = w >> (2 * k);
        m = w << (2 * k);
        return {l[0], l[1], 1'b1, fr, m[7], m[6], 1'b1, fr};
    endfunction

    task automatic test_reset();
        logic [7:0] obs;
        R = 1'b1; E = 1'b1; DATA_VALID = 1'b1; DATA_IN = 8'hAA;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_tests++;
            if ({rdy_l, rdy_m} !== 2'b00) begin
                n_fail++; $display("FAIL reset_ready cyc%0d got=%b want=00", i, {rdy_l, rdy_m});
            end
            step(obs);
            n_tests++;
            if (obs !== IDLE_OBS) begin
                n_fail++; $display("FAIL reset_out cyc%0d got=%b want=%b", i, obs, IDLE_OBS);
            end
        end
        R = 1'b0; DATA_VALID = 1'b0;
        #1;
        n_tests++;
        if ({rdy_l, rdy_m} !== 2'b11) begin
            n_fail++; $display("FAIL reset_release_ready got=%b want=11", {rdy_l, rdy_m});
        end
    endtask

    task automatic test_single();
        logic [7:0] obs;
        logic [7:0] w;
        w = 8'h00;
        DATA_IN = 8'hB4; DATA_VALID = 1'b1; sb.push_back(8'hB4);
        step(obs);
        DATA_VALID = 1'b0;
        n_tests++;
        if (obs !== IDLE_OBS) begin
            n_fail++; $display("FAIL single_accept_cycle got=%b want=%b", obs, IDLE_OBS);
        end
        for (int k = 0; k < 4; k++) begin
            step(obs);
            if (k == 0) w = sb.pop_front();
            n_tests++;
            if (obs !== exp_data(w, k, k == 0)) begin
                n_fail++; $display("FAIL single_pair%0d got=%b want=%b", k, obs, exp_data(w, k, k == 0));
            end
        end
        step(obs);
        n_tests++;
        if (obs !== IDLE_OBS) begin
            n_fail++; $display("FAIL single_tail got=%b want=%b", obs, IDLE_OBS);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] obs;
        logic [7:0] w;
        w = 8'h00;
        DATA_IN = 8'hFF; DATA_VALID = 1'b1; sb.push_back(8'hFF);
        step(obs);
        for (int c = 0; c < 8; c++) begin
            if (c == 0) begin
                DATA_IN = 8'h00; sb.push_back(8'h00);
                #1;
                n_tests++;
                if ({rdy_l, rdy_m} !== 2'b11) begin
                    n_fail++; $display("FAIL b2b_ready_on_load got=%b want=11", {rdy_l, rdy_m});
                end
            end else begin
                DATA_VALID = 1'b0;
            end
            if (c == 1) begin
                DATA_VALID = 1'b1;
                #1;
                n_tests++;
                if ({rdy_l, rdy_m} !== 2'b00) begin
                    n_fail++; $display("FAIL b2b_ready_full got=%b want=00", {rdy_l, rdy_m});
                end
                DATA_VALID = 1'b0;
            end
            step(obs);
            if ((c % 4) == 0) w = sb.pop_front();
            n_tests++;
            if (obs !== exp_data(w, c % 4, (c % 4) == 0)) begin
                n_fail++; $display("FAIL b2b_cyc%0d got=%b want=%b", c, obs, exp_data(w, c % 4, (c % 4) == 0));
            end
        end
        step(obs);
        n_tests++;
        if (obs !== IDLE_OBS) begin
            n_fail++; $display("FAIL b2b_tail got=%b want=%b", obs, IDLE_OBS);
        end
    endtask

    task automatic test_enable();
        logic [7:0] obs;
        logic [7:0] w;
        w = 8'h00;
        DATA_IN = 8'hB4; DATA_VALID = 1'b1; sb.push_back(8'hB4);
        step(obs);
        DATA_VALID = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k == 2) begin
                E = 1'b0; DATA_VALID = 1'b1;
                #1;
                n_tests++;
                if ({rdy_l, rdy_m} !== 2'b00) begin
                    n_fail++; $display("FAIL enable_ready got=%b want=00", {rdy_l, rdy_m});
                end
                for (int h = 0; h < 3; h++) begin
                    step(obs);
                    n_tests++;
                    if (obs !== exp_data(w, 1, 1'b0)) begin
                        n_fail++; $display("FAIL enable_hold%0d got=%b want=%b", h, obs, exp_data(w, 1, 1'b0));
                    end
                end
                E = 1'b1; DATA_VALID = 1'b0;
            end
            step(obs);
            if (k == 0) w = sb.pop_front();
            n_tests++;
            if (obs !== exp_data(w, k, k == 0)) begin
                n_fail++; $display("FAIL enable_pair%0d got=%b want=%b", k, obs, exp_data(w, k, k == 0));
            end
        end
        step(obs);
        n_tests++;
        if (obs !== IDLE_OBS) begin
            n_fail++; $display("FAIL enable_tail got=%b want=%b", obs, IDLE_OBS);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] obs;
        logic [7:0] w;
        w = 8'h00;
        DATA_IN = 8'h5A; DATA_VALID = 1'b1; sb.push_back(8'h5A);
        step(obs);
        DATA_IN = 8'hC3; sb.push_back(8'hC3);
        for (int k = 0; k < 2; k++) begin
            step(obs);
            DATA_VALID = 1'b0;
            if (k == 0) w = sb.pop_front();
            n_tests++;
            if (obs !== exp_data(w, k, k == 0)) begin
                n_fail++; $display("FAIL rstmid_pair%0d got=%b want=%b", k, obs, exp_data(w, k, k == 0));
            end
        end
        R = 1'b1;
        step(obs);
        sb.delete();
        n_tests++;
        if (obs !== IDLE_OBS) begin
            n_fail++; $display("FAIL rstmid_truncate got=%b want=%b", obs, IDLE_OBS);
        end
        R = 1'b0;
        #1;
        n_tests++;
        if ({rdy_l, rdy_m} !== 2'b11) begin
            n_fail++; $display("FAIL rstmid_hb_cleared got=%b want=11", {rdy_l, rdy_m});
        end
        for (int i = 0; i < 5; i++) begin
            step(obs);
            n_tests++;
            if (obs !== IDLE_OBS) begin
                n_fail++; $display("FAIL rstmid_stale%0d got=%b want=%b", i, obs, IDLE_OBS);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_enable();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
